uar_top: RTL and testbench
==========================

// Module: uar_top
// PURPOSE
// - UART receive side: deserialises the frame produced by our UART transmitter, i.e. start(0), DATA_W data bits LSB first, stop(1).
// - One bit per clk_x period: the transmitter drives on negedge; this block samples the line on posedge (mid-bit).
// - Presents the byte on a valid/ack handshake to the host logic, and flags framing and overrun errors.
// PARAMETERS
// - DATA_W       8  data bits per frame
// - SYNC_STAGES  2  flip-flops in the ser_in synchroniser chain (>=1)
// PORTS
// - clk_x      in   1       bit clock; all logic on posedge
// - rst_p      in   1       reset, asynchronous, active-low
// - ser_in     in   1       serial line; idles high
// - dout_ack   in   1       host consumed dout_byte; clears dout_valid
// - dout_byte  out  DATA_W  last correctly framed byte
// - dout_valid out  1       high from byte completion until acknowledged
// - frame_err  out  1       one-cycle pulse: stop bit sampled as 0
// - overrun    out  1       one-cycle pulse: new byte completed while dout_valid still set
// BEHAVIOUR
// - Reset (rst_p=0, async): sync chain=all 1s; state=IDLE; shift_reg=0; bit_cnt=0; dout_byte=0; all flags 0.
// - rx_bit = last synchroniser stage. Every decision below uses rx_bit.
// - The states live in uar_sm:
//   - IDLE: rx_bit==0 (start bit) -> DATA with bit_cnt=0; otherwise stay.
//   - DATA: shift_reg <= {rx_bit, shift_reg[DATA_W-1:1]} and bit_cnt++. When bit_cnt==DATA_W-1 -> STOP.
//   - STOP, rx_bit==1: dout_byte <= shift_reg and dout_valid <= 1 -> IDLE. Back-to-back frames must work: a start bit in the very next cycle is accepted.
//   - STOP, rx_bit==0: frame_err pulse; dout_byte and dout_valid unchanged -> BRK.
//   - BRK: wait for rx_bit==1 -> IDLE. A held-low line (break) must not be taken as repeated start bits.
// - bit_cnt width is clog2(DATA_W). It is cleared on entry to DATA. No wrap occurs inside a frame.
// - Latency:
//   - Stop bit on ser_in at posedge n: rx_bit shows it at n+SYNC_STAGES-1.
//   - dout_valid/frame_err go high after posedge n+SYNC_STAGES.
// - dout_valid rules:
//   - Cleared on dout_ack.
//   - Byte completion with dout_valid=1 and dout_ack=0: overrun pulse, dout_byte overwritten, dout_valid stays 1.
//   - Completion and dout_ack in the same cycle: ack applies first; new byte loaded; dout_valid=1; no overrun.
//   - dout_ack while dout_valid=0: ignored.
// - frame_err and overrun are single-cycle pulses, never sticky.
// - Reset mid-frame: the partial frame is discarded, and the block restarts in IDLE with the line treated as high.
// STRUCTURE
// - Shared package: rx state encoding (IDLE, DATA, STOP, BRK), DATA_W default, frame-format constants (START_LVL=0, STOP_LVL=1).
// - Sub-module uar_sm:
//   - Inputs: rx_bit, bit_cnt. Outputs: state, data_bits_sig, stop_bit_sig.
//   - Mirrors the transmitter's state machine split.
// - uar_top holds: synchroniser, shift register, bit counter, output/handshake registers.
// TESTING (tx model drives ser_in on negedge, 1 bit/clk)
// - Single frame 0xA5, no ack -> dout_byte=0xA5, dout_valid=1 at the stated latency, and it holds; frame_err=0, overrun=0.
// - Back-to-back frames 0x00 then 0xFF with zero idle cycles, ack issued one cycle after each valid -> two valid events, 0x00 then 0xFF.
// - Framing/break: frame 0x3C with stop bit 0, line held low 12 more cycles, then high 3 cycles, then frame 0xC3:
//   - frame_err pulses exactly once; dout_valid stays 0 until 0xC3 arrives.
//   - No spurious bytes during the low period.
// - Overrun: send 0x11 and 0x22 with no ack -> overrun pulses once at 0x22 completion; dout_byte=0x22; dout_valid=1.
//   Repeat with dout_ack asserted in the completion cycle of 0x22 -> no overrun.
// - Reset mid-frame: rst_p low for 1 cycle after 4 data bits of 0x5A, then a full frame 0x96 -> only 0x96 reported; all outputs 0 during reset.

Source files
------------

// File: rtl/uar_pkg.sv
// Shared definitions for the UART receive path: state encoding and frame-format levels.
package uar_pkg;

  localparam int unsigned DATA_W_DEF = 8;

  localparam logic START_LVL = 1'b0;
  localparam logic STOP_LVL  = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_DATA = 2'd1,
    ST_STOP = 2'd2,
    ST_BRK  = 2'd3
  } rx_state_e;

endpackage

// File: rtl/uar_sm.sv
// Receive frame sequencer: walks IDLE -> DATA -> STOP, parking in BRK while a
// failed stop bit is followed by a held-low line.
module uar_sm
  import uar_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned CNT_W  = (DATA_W > 1) ? $clog2(DATA_W) : 1
) (
  input  logic             clk_x,
  input  logic             rst_p,
  input  logic             rx_bit,
  input  logic [CNT_W-1:0] bit_cnt,
  output logic [1:0]       state,
  output logic             data_bits_sig,
  output logic             stop_bit_sig
);

  rx_state_e r_state;
  logic      r_data_bits;
  logic      r_stop_bit;

  // Phase flags are registered alongside the state so they always equal (state==DATA/STOP).
  always_ff @(posedge clk_x or negedge rst_p) begin
    if (!rst_p) begin
      r_state     <= ST_IDLE;
      r_data_bits <= 1'b0;
      r_stop_bit  <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (rx_bit == START_LVL) begin
            r_state     <= ST_DATA;
            r_data_bits <= 1'b1;
          end
        end
        ST_DATA: begin
          if (bit_cnt == CNT_W'(DATA_W - 1)) begin
            r_state     <= ST_STOP;
            r_data_bits <= 1'b0;
            r_stop_bit  <= 1'b1;
          end
        end
        ST_STOP: begin
          r_stop_bit <= 1'b0;
          if (rx_bit == STOP_LVL) r_state <= ST_IDLE;
          else                    r_state <= ST_BRK;
        end
        ST_BRK: begin
          if (rx_bit == STOP_LVL) r_state <= ST_IDLE;
        end
        default: begin
          r_state     <= ST_IDLE;
          r_data_bits <= 1'b0;
          r_stop_bit  <= 1'b0;
        end
      endcase
    end
  end

  assign state         = r_state;
  assign data_bits_sig = r_data_bits;
  assign stop_bit_sig  = r_stop_bit;

endmodule

// File: rtl/uar_top.sv
// UART receiver: synchronises ser_in, deserialises start/data/stop frames and
// hands each good byte to the host over a valid/ack handshake.
module uar_top
  import uar_pkg::*;
#(
  parameter int unsigned DATA_W      = DATA_W_DEF,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic              clk_x,
  input  logic              rst_p,
  input  logic              ser_in,
  input  logic              dout_ack,
  output logic [DATA_W-1:0] dout_byte,
  output logic              dout_valid,
  output logic              frame_err,
  output logic              overrun
);

  localparam int unsigned CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

  logic [SYNC_STAGES-1:0] r_sync;
  logic [DATA_W-1:0]      r_shift;
  logic [CNT_W-1:0]       r_cnt;
  logic [DATA_W-1:0]      r_byte;
  logic                   r_valid;
  logic                   r_ferr;
  logic                   r_ovr;

  logic       w_rx_bit;
  logic [1:0] w_state;
  logic       w_data_sig;
  logic       w_stop_sig;
  logic       w_start;
  logic       w_done;
  logic       w_ferr;

  // Reset loads all ones so the line looks idle-high and no false start is seen.
  always_ff @(posedge clk_x or negedge rst_p) begin
    if (!rst_p) begin
      r_sync <= '1;
    end else begin
      r_sync[0] <= ser_in;
      for (int unsigned i = 1; i < SYNC_STAGES; i++) begin
        r_sync[i] <= r_sync[i-1];
      end
    end
  end

  assign w_rx_bit = r_sync[SYNC_STAGES-1];

  uar_sm #(
    .DATA_W (DATA_W),
    .CNT_W  (CNT_W)
  ) u_sm (
    .clk_x         (clk_x),
    .rst_p         (rst_p),
    .rx_bit        (w_rx_bit),
    .bit_cnt       (r_cnt),
    .state         (w_state),
    .data_bits_sig (w_data_sig),
    .stop_bit_sig  (w_stop_sig)
  );

  assign w_start = (w_state == ST_IDLE) && (w_rx_bit == START_LVL);
  assign w_done  = w_stop_sig && (w_rx_bit == STOP_LVL);
  assign w_ferr  = w_stop_sig && (w_rx_bit != STOP_LVL);

  always_ff @(posedge clk_x or negedge rst_p) begin
    if (!rst_p) begin
      r_shift <= '0;
      r_cnt   <= '0;
    end else if (w_start) begin
      r_cnt <= '0;
    end else if (w_data_sig) begin
      r_shift <= {w_rx_bit, r_shift[DATA_W-1:1]};
      r_cnt   <= r_cnt + CNT_W'(1);
    end
  end

  // A completion wins over a same-cycle ack; overrun only if the old byte was never taken.
  always_ff @(posedge clk_x or negedge rst_p) begin
    if (!rst_p) begin
      r_byte  <= '0;
      r_valid <= 1'b0;
      r_ferr  <= 1'b0;
      r_ovr   <= 1'b0;
    end else begin
      r_ferr <= w_ferr;
      r_ovr  <= 1'b0;
      if (w_done) begin
        r_byte  <= r_shift;
        r_valid <= 1'b1;
        r_ovr   <= r_valid && !dout_ack;
      end else if (dout_ack) begin
        r_valid <= 1'b0;
      end
    end
  end

  assign dout_byte  = r_byte;
  assign dout_valid = r_valid;
  assign frame_err  = r_ferr;
  assign overrun    = r_ovr;

endmodule

// File: tb/tb_uar_top.sv
// Directed bench for uar_top: a negedge-driven transmitter model and hand-computed expectations.
module tb_uar_top;

  logic       clk_x;
  logic       rst_p;
  logic       ser_in;
  logic       man_ack;
  logic       ack_auto = 1'b0;
  logic       auto_en;
  logic       dout_ack;
  logic [7:0] dout_byte;
  logic       dout_valid;
  logic       frame_err;
  logic       overrun;

  int tests = 0;
  int fails = 0;
  int fe_cnt = 0;
  int ov_cnt = 0;
  int vr_cnt = 0;
  logic prev_v = 1'b0;
  logic [7:0] got_q[$];

  int fe_b, ov_b, vr_b, qb;

  assign dout_ack = man_ack | ack_auto;

  uar_top #(
    .DATA_W      (8),
    .SYNC_STAGES (2)
  ) dut (
    .clk_x      (clk_x),
    .rst_p      (rst_p),
    .ser_in     (ser_in),
    .dout_ack   (dout_ack),
    .dout_byte  (dout_byte),
    .dout_valid (dout_valid),
    .frame_err  (frame_err),
    .overrun    (overrun)
  );

  initial clk_x = 1'b0;
  always #5 clk_x = ~clk_x;

  // Event counters, byte capture on valid rising, and the optional one-cycle-late acker.
  always @(negedge clk_x) begin
    if (frame_err) fe_cnt++;
    if (overrun) ov_cnt++;
    if (dout_valid && !prev_v) begin
      vr_cnt++;
      got_q.push_back(dout_byte);
    end
    prev_v = dout_valid;
    ack_auto = auto_en && dout_valid && !ack_auto;
  end

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Returns on the negedge that drives the stop bit (the next posedge is "n").
  task automatic send_frame(input logic [7:0] d, input logic stop_b);
    @(negedge clk_x); ser_in = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk_x); ser_in = d[i];
    end
    @(negedge clk_x); ser_in = stop_b;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk_x);
  endtask

  task automatic snap();
    fe_b = fe_cnt; ov_b = ov_cnt; vr_b = vr_cnt; qb = got_q.size();
  endtask

  initial begin
    ser_in = 1'b1; man_ack = 1'b0; auto_en = 1'b0; rst_p = 1'b1;
    #1 rst_p = 1'b0;
    idle(2);
    check("rst_byte",  dout_byte, 8'h00);
    check("rst_valid", {7'd0, dout_valid}, 8'h00);
    check("rst_ferr",  {7'd0, frame_err}, 8'h00);
    check("rst_ovr",   {7'd0, overrun}, 8'h00);
    rst_p = 1'b1;
    idle(3);

    // Single frame 0xA5, latency and hold
    #1 snap();
    send_frame(8'hA5, 1'b1);
    idle(2);
    check("a5_valid_n1", {7'd0, dout_valid}, 8'h00);
    idle(1);
    check("a5_valid_n2", {7'd0, dout_valid}, 8'h01);
    check("a5_byte", dout_byte, 8'hA5);
    idle(6);
    check("a5_hold_valid", {7'd0, dout_valid}, 8'h01);
    check("a5_hold_byte", dout_byte, 8'hA5);
    #1;
    check("a5_ferr_cnt", 8'(fe_cnt - fe_b), 8'd0);
    check("a5_ovr_cnt",  8'(ov_cnt - ov_b), 8'd0);
    @(negedge clk_x); man_ack = 1'b1;
    @(negedge clk_x); man_ack = 1'b0;
    check("a5_ack_clear", {7'd0, dout_valid}, 8'h00);
    check("a5_ack_byte", dout_byte, 8'hA5);
    idle(2);

    // Back-to-back 0x00, 0xFF with auto ack one cycle after valid
    #1 snap();
    auto_en = 1'b1;
    send_frame(8'h00, 1'b1);
    send_frame(8'hFF, 1'b1);
    idle(6);
    #1;
    check("b2b_events", 8'(vr_cnt - vr_b), 8'd2);
    check("b2b_first",  got_q[qb], 8'h00);
    check("b2b_second", got_q[qb+1], 8'hFF);
    check("b2b_ovr_cnt", 8'(ov_cnt - ov_b), 8'd0);
    check("b2b_valid_after", {7'd0, dout_valid}, 8'h00);
    auto_en = 1'b0;
    idle(2);

    // Framing error then break, then a clean frame
    #1 snap();
    send_frame(8'h3C, 1'b0);
    for (int i = 0; i < 12; i++) begin
      @(negedge clk_x); ser_in = 1'b0;
      if (i == 2) check("fe_pulse_hi", {7'd0, frame_err}, 8'h01);
      if (i == 3) check("fe_pulse_lo", {7'd0, frame_err}, 8'h00);
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk_x); ser_in = 1'b1;
    end
    check("fe_valid_low", {7'd0, dout_valid}, 8'h00);
    check("fe_byte_kept", dout_byte, 8'hFF);
    #1;
    check("fe_no_spurious", 8'(vr_cnt - vr_b), 8'd0);
    send_frame(8'hC3, 1'b1);
    idle(4);
    check("fe_c3_valid", {7'd0, dout_valid}, 8'h01);
    check("fe_c3_byte", dout_byte, 8'hC3);
    #1;
    check("fe_once", 8'(fe_cnt - fe_b), 8'd1);
    check("fe_events", 8'(vr_cnt - vr_b), 8'd1);
    @(negedge clk_x); man_ack = 1'b1;
    @(negedge clk_x); man_ack = 1'b0;
    idle(2);

    // Overrun: 0x11 then 0x22 with no ack
    #1 snap();
    send_frame(8'h11, 1'b1);
    send_frame(8'h22, 1'b1);
    idle(2);
    check("ovr_pre", {7'd0, overrun}, 8'h00);
    idle(1);
    check("ovr_pulse", {7'd0, overrun}, 8'h01);
    check("ovr_byte", dout_byte, 8'h22);
    check("ovr_valid", {7'd0, dout_valid}, 8'h01);
    idle(1);
    check("ovr_post", {7'd0, overrun}, 8'h00);
    #1;
    check("ovr_once", 8'(ov_cnt - ov_b), 8'd1);
    @(negedge clk_x); man_ack = 1'b1;
    @(negedge clk_x); man_ack = 1'b0;
    check("ovr_ack_clear", {7'd0, dout_valid}, 8'h00);
    idle(2);

    // Same, but ack lands in the 0x22 completion cycle
    #1 snap();
    send_frame(8'h11, 1'b1);
    send_frame(8'h22, 1'b1);
    idle(2);
    man_ack = 1'b1;
    @(negedge clk_x); man_ack = 1'b0;
    check("ack_cmp_ovr", {7'd0, overrun}, 8'h00);
    check("ack_cmp_valid", {7'd0, dout_valid}, 8'h01);
    check("ack_cmp_byte", dout_byte, 8'h22);
    idle(2);
    #1;
    check("ack_cmp_ovr_cnt", 8'(ov_cnt - ov_b), 8'd0);
    @(negedge clk_x); man_ack = 1'b1;
    @(negedge clk_x); man_ack = 1'b0;
    idle(2);

    // Reset after 4 data bits of 0x5A, then 0x96
    @(negedge clk_x); ser_in = 1'b0;
    for (int i = 0; i < 4; i++) begin
      logic [7:0] d5a;
      d5a = 8'h5A;
      @(negedge clk_x); ser_in = d5a[i];
    end
    @(negedge clk_x); rst_p = 1'b0; ser_in = 1'b1;
    #1;
    check("mid_rst_byte",  dout_byte, 8'h00);
    check("mid_rst_valid", {7'd0, dout_valid}, 8'h00);
    check("mid_rst_ferr",  {7'd0, frame_err}, 8'h00);
    check("mid_rst_ovr",   {7'd0, overrun}, 8'h00);
    @(negedge clk_x); rst_p = 1'b1;
    idle(2);
    #1 snap();
    send_frame(8'h96, 1'b1);
    idle(4);
    check("post_rst_byte", dout_byte, 8'h96);
    #1;
    check("post_rst_events", 8'(vr_cnt - vr_b), 8'd1);
    check("post_rst_got", got_q[qb], 8'h96);
    check("post_rst_ferr", 8'(fe_cnt - fe_b), 8'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
